pwm_multi_ch: RTL and testbench

- Multi-channel, parametrised PWM generator for the fan-control datapath. It drives NUM_CH outputs from one shared prescaler and step counter.
- Duty values are double-buffered. Software writes land in shadow registers, which are transferred to active registers only at a PWM period boundary, so outputs never glitch mid-period.
- Successor to the single-channel PWM block. It adds channel count, duty clamping, per-channel enable, a period strobe and an update-pending flag.

---
 rtl/pwm_multi_ch.sv | 111 +++++++++++
 tb/tb_pwm_multi_ch.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: shared prescaler/step counter, double-buffered duties.
// Optional soft ramping of active duties enabled by defining PWM_MULTI_CH_SOFT_RAMP_EN.
module pwm_multi_ch #(
  parameter int SYS_CLK_FREQ = 100_000_000,
  parameter int PWM_FREQ     = 10_000,
  parameter int DUTY_STEPS   = 128,
  parameter int NUM_CH       = 4,
  parameter int RAMP_STEP    = 1,
  localparam int DUTY_W      = $clog2(DUTY_STEPS + 1),
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DUTY_W-1:0] wr_duty,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick,
  output logic              update_pending
);

  localparam int PRESC_RAW = SYS_CLK_FREQ / (PWM_FREQ * DUTY_STEPS);
  localparam int PRESC     = (PRESC_RAW < 1) ? 1 : PRESC_RAW;
  localparam int PRESC_W   = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int STEP_W    = $clog2(DUTY_STEPS);

  // A ramp step of at least DUTY_STEPS always lands on the shadow value: a direct copy.
`ifdef PWM_MULTI_CH_SOFT_RAMP_EN
  localparam int RAMP_EFF  = RAMP_STEP;
`else
  localparam int RAMP_EFF  = (RAMP_STEP > DUTY_STEPS) ? RAMP_STEP : DUTY_STEPS;
`endif

  logic [PRESC_W-1:0] r_presc;
  logic [STEP_W-1:0]  r_step_cnt;
  logic [DUTY_W-1:0]  r_shadow [NUM_CH];
  logic [DUTY_W-1:0]  r_active [NUM_CH];
  logic [DUTY_W-1:0]  w_active_nxt [NUM_CH];
  logic [DUTY_W-1:0]  w_wr_duty_clamped;
  logic               w_step_tick;
  logic               w_boundary;
  logic               w_wr_valid;
  logic               w_all_match;

  assign w_step_tick       = (r_presc == PRESC_W'(PRESC - 1));
  assign w_boundary        = w_step_tick && (r_step_cnt == STEP_W'(DUTY_STEPS - 1));
  assign w_wr_valid        = wr_en && (int'(wr_ch) < NUM_CH);
  assign w_wr_duty_clamped = (int'(wr_duty) > DUTY_STEPS) ? DUTY_W'(DUTY_STEPS) : wr_duty;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_all_match = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      w_active_nxt[i] = r_shadow[i];
      if (int'(r_shadow[i]) > int'(r_active[i]) + RAMP_EFF)
        w_active_nxt[i] = r_active[i] + DUTY_W'(RAMP_EFF);
      else if (int'(r_shadow[i]) + RAMP_EFF < int'(r_active[i]))
        w_active_nxt[i] = r_active[i] - DUTY_W'(RAMP_EFF);
      w_all_match = w_all_match && (w_active_nxt[i] == r_shadow[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc     <= '0;
      r_step_cnt  <= '0;
      period_tick <= 1'b0;
    end else begin
      period_tick <= w_boundary;
      if (w_step_tick) begin
        r_presc    <= '0;
        r_step_cnt <= (r_step_cnt == STEP_W'(DUTY_STEPS - 1)) ? '0 : r_step_cnt + 1'b1;
      end else begin
        r_presc    <= r_presc + 1'b1;
      end
    end
  end

  // NOTE: the duty arrays are small register files, reset explicitly so duties start at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      update_pending <= 1'b0;
    end else begin
      // The transfer reads the pre-write shadow; a same-edge write waits for the next boundary.
      if (w_boundary) begin
        for (int i = 0; i < NUM_CH; i++) r_active[i] <= w_active_nxt[i];
        if (w_all_match) update_pending <= 1'b0;
      end
      if (w_wr_valid) begin
        r_shadow[wr_ch] <= w_wr_duty_clamped;
        update_pending  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        pwm_out[i] <= ch_en[i] && (DUTY_W'(r_step_cnt) < r_active[i]);
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Self-checking bench for pwm_multi_ch: directed steps plus random writes against a
// period-arithmetic reference model; PWM_MULTI_CH_SOFT_RAMP_EN selects the ramp model.
module tb_pwm_multi_ch;

  localparam int SYS    = 1000;
  localparam int PF     = 10;
  localparam int DS     = 10;
  localparam int NC     = 3;
  localparam int RS     = 2;
  localparam int PRESC  = 10;
  localparam int PER    = PRESC * DS;
  localparam int DW     = 4;
  localparam int CW     = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [CW-1:0] wr_ch = '0;
  logic [DW-1:0] wr_duty = '0;
  logic [NC-1:0] ch_en = '0;
  logic [NC-1:0] pwm_out;
  logic          period_tick;
  logic          update_pending;

  pwm_multi_ch #(
    .SYS_CLK_FREQ(SYS), .PWM_FREQ(PF), .DUTY_STEPS(DS), .NUM_CH(NC), .RAMP_STEP(RS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .ch_en(ch_en), .pwm_out(pwm_out), .period_tick(period_tick),
    .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: state is derived from the number of edges since reset release.
  int            m_edge;
  int            m_sh  [NC];
  int            m_act [NC];
  bit            m_pend;
  bit            m_tick;
  logic [NC-1:0] m_pwm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, m_edge, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_edge = 0;
    m_pend = 0;
    m_tick = 0;
    m_pwm  = '0;
    for (int i = 0; i < NC; i++) begin
      m_sh[i]  = 0;
      m_act[i] = 0;
    end
  endtask

  task automatic model_edge();
    int  step_before;
    bit  all_eq;
    step_before = (m_edge / PRESC) % DS;
    for (int i = 0; i < NC; i++) m_pwm[i] = ch_en[i] && (step_before < m_act[i]);
    m_edge++;
    m_tick = (m_edge % PER) == 0;
    if (m_tick) begin
      all_eq = 1;
      for (int i = 0; i < NC; i++) begin
`ifdef PWM_MULTI_CH_SOFT_RAMP_EN
        if (m_sh[i] - m_act[i] > RS)       m_act[i] = m_act[i] + RS;
        else if (m_act[i] - m_sh[i] > RS)  m_act[i] = m_act[i] - RS;
        else                               m_act[i] = m_sh[i];
`else
        m_act[i] = m_sh[i];
`endif
        if (m_act[i] != m_sh[i]) all_eq = 0;
      end
      if (all_eq) m_pend = 0;
    end
    if (wr_en && int'(wr_ch) < NC) begin
      m_sh[wr_ch] = (int'(wr_duty) > DS) ? DS : int'(wr_duty);
      m_pend = 1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
    chk("period_tick", 32'(period_tick), 32'(m_tick));
    chk("update_pending", 32'(update_pending), 32'(m_pend));
  endtask

  task automatic idle(input int k);
    repeat (k) cyc();
  endtask

  task automatic do_write(input int ch, input int d);
    wr_en   = 1'b1;
    wr_ch   = CW'(ch);
    wr_duty = DW'(d);
    cyc();
    wr_en   = 1'b0;
  endtask

  // Leaves the bench so that the next edge is a period boundary.
  task automatic to_boundary();
    while (((m_edge + 1) % PER) != 0) cyc();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_pwm_out", 32'(pwm_out), 32'd0);
    chk("rst_period_tick", 32'(period_tick), 32'd0);
    chk("rst_update_pending", 32'(update_pending), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();
    ch_en = 3'b111;
    idle(250);

    ch_en = 3'b001;
    idle(30);
    do_write(0, 3);
    chk("pending_after_wr", 32'(update_pending), 32'd1);
    idle(270);

    ch_en = 3'b111;
    do_write(1, 15);
    do_write(3, 9);
    idle(220);

    to_boundary();
    do_write(0, 5);
    chk("pending_boundary_wr", 32'(update_pending), 32'd1);
    idle(200);

    to_boundary();
    idle(22);
    ch_en = 3'b110;
    cyc();
    chk("ch0_disabled", 32'(pwm_out[0]), 32'd0);
    idle(10);
    ch_en = 3'b111;
    idle(15);
    do_reset();
    idle(150);

    to_boundary();
    idle(37);
    do_write(0, 7);
    idle(480);

    for (int k = 0; k < 40; k++) begin
      ch_en = NC'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) to_boundary();
      do_write($urandom_range(0, 3), $urandom_range(0, 15));
      idle($urandom_range(1, 90));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
